// File: rtl/bus_ctrl_pkg.sv
// bus_ctrl shared definitions: default sizes, source names, one-hot helper.
package bus_ctrl_pkg;

  localparam int W_DEF     = 16;
  localparam int NSRC_DEF  = 13;
  localparam int NDST_DEF  = 16;
  localparam int DEPTH_DEF = 4;
  localparam int OH_MAX    = 64;

  localparam int SRC_R  = 0;
  localparam int SRC_DR = 1;
  localparam int SRC_TR = 2;
  localparam int SRC_PC = 3;
  localparam int SRC_AC = 4;
  localparam int SRC_DM = 5;
  localparam int SRC_IM = 6;
  localparam int SRC_R1 = 7;
  localparam int SRC_R2 = 8;
  localparam int SRC_RI = 9;
  localparam int SRC_RJ = 10;
  localparam int SRC_RK = 11;
  localparam int SRC_SP = 12;

  // Out-of-range index yields all zeros.
  function automatic logic [OH_MAX-1:0] onehot(
    input int unsigned idx,
    input int unsigned n
  );
    onehot = '0;
    if (idx < n && idx < OH_MAX) onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/bus_req_fifo.sv
// Generic synchronous FIFO holding bus transfer requests.
module bus_req_fifo
  import bus_ctrl_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [PW-1:0]    wr_q, wr_d;
  logic [PW-1:0]    rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign head    = mem_q[rd_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) begin
      mem_d[wr_q] = din;
      wr_d        = wr_q + 1'b1;
    end
    if (do_pop) rd_d = rd_q + 1'b1;
    cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/bus_ctrl.sv
// Registered shared-bus controller with queued {src,dst} transfers.
// Optional sticky illegal-source flag enabled by BUS_CTRL_ERR_EN.
module bus_ctrl
  import bus_ctrl_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int NSRC  = NSRC_DEF,
  parameter int NDST  = NDST_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NSRC*W-1:0]       src_bus,
  input  logic                    req_valid,
  input  logic [$clog2(NSRC)-1:0] req_src,
  input  logic [$clog2(NDST)-1:0] req_dst,
  output logic                    req_ready,
  input  logic                    bus_hold,
  output logic [W-1:0]            bus_out,
  output logic                    out_valid,
  output logic [NDST-1:0]         ld_en,
  input  logic                    err_clr,
  output logic                    err_sel
);

  localparam int SW = $clog2(NSRC);
  localparam int DW = $clog2(NDST);

  logic [SW+DW-1:0] head;
  logic [SW-1:0]    head_src;
  logic [DW-1:0]    head_dst;
  logic             full;
  logic             empty;
  logic             issue;

  logic [W-1:0]     bus_out_q, bus_out_d;
  logic             out_valid_q, out_valid_d;
  logic [NDST-1:0]  ld_en_q, ld_en_d;
  logic [W-1:0]     sel;

  bus_req_fifo #(
    .WIDTH (SW + DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (req_valid),
    .din   ({req_src, req_dst}),
    .pop   (issue),
    .full  (full),
    .empty (empty),
    .head  (head)
  );

  assign req_ready = !full;
  assign head_src  = head[DW +: SW];
  assign head_dst  = head[DW-1:0];
  assign issue     = !empty && !bus_hold;

  // Illegal sources match no arm and leave sel at zero.
  always_comb begin
    sel = '0;
    for (int k = 0; k < NSRC; k++)
      if (32'(head_src) == k) sel = src_bus[k*W +: W];
  end

  always_comb begin
    bus_out_d   = bus_out_q;
    out_valid_d = 1'b0;
    ld_en_d     = '0;
    if (issue) begin
      bus_out_d   = sel;
      out_valid_d = 1'b1;
      ld_en_d     = NDST'(onehot(32'(head_dst), NDST));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_out_q   <= '0;
      out_valid_q <= 1'b0;
      ld_en_q     <= '0;
    end else begin
      bus_out_q   <= bus_out_d;
      out_valid_q <= out_valid_d;
      ld_en_q     <= ld_en_d;
    end
  end

  assign bus_out   = bus_out_q;
  assign out_valid = out_valid_q;
  assign ld_en     = ld_en_q;

`ifdef BUS_CTRL_ERR_EN
  logic err_q, err_d;
  logic illegal;

  assign illegal = 32'(head_src) >= NSRC;

  always_comb begin
    err_d = err_q;
    if (issue && illegal) err_d = 1'b1;
    if (err_clr) err_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign err_sel = err_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign err_sel        = 1'b0;
`endif

endmodule

// File: tb/tb_bus_ctrl.sv
// Directed self-checking bench for bus_ctrl.
module tb_bus_ctrl;
  import bus_ctrl_pkg::*;

  localparam int W    = 16;
  localparam int NSRC = 13;
  localparam int NDST = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NSRC*W-1:0] src_bus = '0;
  logic              req_valid = 1'b0;
  logic [3:0]        req_src = '0;
  logic [3:0]        req_dst = '0;
  logic              req_ready;
  logic              bus_hold = 1'b0;
  logic [W-1:0]      bus_out;
  logic              out_valid;
  logic [NDST-1:0]   ld_en;
  logic              err_clr = 1'b0;
  logic              err_sel;

  int n_chk = 0;
  int n_fail = 0;
  logic exp_err;

  bus_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .src_bus   (src_bus),
    .req_valid (req_valid),
    .req_src   (req_src),
    .req_dst   (req_dst),
    .req_ready (req_ready),
    .bus_hold  (bus_hold),
    .bus_out   (bus_out),
    .out_valid (out_valid),
    .ld_en     (ld_en),
    .err_clr   (err_clr),
    .err_sel   (err_sel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input int s, input int d);
    req_valid = 1'b1;
    req_src   = 4'(s);
    req_dst   = 4'(d);
  endtask

  initial begin
`ifdef BUS_CTRL_ERR_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    for (int k = 0; k < NSRC; k++) src_bus[k*W +: W] = 16'(10 + k);

    #12;
    chk("rst_bus", 64'(bus_out), 0);
    chk("rst_ov", 64'(out_valid), 0);
    chk("rst_ld", 64'(ld_en), 0);
    chk("rst_err", 64'(err_sel), 0);
    chk("rst_rdy", 64'(req_ready), 1);
    step();
    rst_n = 1'b1;
    step();

    // single transfer
    req(4, 3);
    step();
    req_valid = 1'b0;
    chk("s1_lat", 64'(out_valid), 0);
    step();
    chk("s1_bus", 64'(bus_out), 14);
    chk("s1_ld", 64'(ld_en), 64'h8);
    chk("s1_ov", 64'(out_valid), 1);
    step();
    chk("s1_ov0", 64'(out_valid), 0);
    chk("s1_hold", 64'(bus_out), 14);
    chk("s1_ld0", 64'(ld_en), 0);

    // back-to-back, no bubbles
    for (int c = 0; c < 9; c++) begin
      if (c < 8) req(c, c);
      else req_valid = 1'b0;
      step();
      if (c >= 1) begin
        chk("b2b_ov", 64'(out_valid), 1);
        chk("b2b_bus", 64'(bus_out), 64'(10 + c - 1));
        chk("b2b_ld", 64'(ld_en), 64'(1) << (c - 1));
      end
    end
    step();
    chk("b2b_end", 64'(out_valid), 0);

    // hold fills queue, then drains in order
    bus_hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req(5 + i, i);
      chk("hold_rdy", 64'(req_ready), 1);
      step();
      chk("hold_ov", 64'(out_valid), 0);
    end
    req(9, 4);
    chk("full_rdy", 64'(req_ready), 0);
    step();
    chk("full_rdy2", 64'(req_ready), 0);
    chk("full_ov", 64'(out_valid), 0);
    bus_hold = 1'b0;
    step();
    chk("dr0_bus", 64'(bus_out), 15);
    chk("dr0_ov", 64'(out_valid), 1);
    chk("dr0_rdy", 64'(req_ready), 1);
    step();
    req_valid = 1'b0;
    chk("dr1_bus", 64'(bus_out), 16);
    for (int i = 2; i < 5; i++) begin
      step();
      chk("dr_bus", 64'(bus_out), 64'(15 + i));
      chk("dr_ld", 64'(ld_en), 64'(1) << i);
    end
    step();
    chk("dr_end", 64'(out_valid), 0);

    // issue-edge sampling of source
    req(2, 5);
    step();
    req_valid = 1'b0;
    src_bus[2*W +: W] = 16'd99;
    step();
    src_bus[2*W +: W] = 16'd12;
    chk("smp_bus", 64'(bus_out), 99);
    chk("smp_ld", 64'(ld_en), 64'h20);
    step();
    chk("smp_reg", 64'(bus_out), 99);

    // illegal source
    req(14, 2);
    step();
    req_valid = 1'b0;
    step();
    chk("ill_bus", 64'(bus_out), 0);
    chk("ill_ov", 64'(out_valid), 1);
    chk("ill_ld", 64'(ld_en), 64'h4);
    chk("ill_err", 64'(err_sel), 64'(exp_err));
    step();
    chk("ill_stk", 64'(err_sel), 64'(exp_err));
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("ill_clr", 64'(err_sel), 0);

    // async reset with queued requests
    req(3, 1);
    step();
    req_valid = 1'b0;
    step();
    chk("pre_bus", 64'(bus_out), 13);
    bus_hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req(i, i);
      step();
    end
    req_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_bus", 64'(bus_out), 0);
    chk("ar_ov", 64'(out_valid), 0);
    chk("ar_ld", 64'(ld_en), 0);
    chk("ar_rdy", 64'(req_ready), 1);
    step();
    rst_n = 1'b1;
    bus_hold = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("post_ov", 64'(out_valid), 0);
      chk("post_bus", 64'(bus_out), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_ctrl.md
# bus_ctrl

Parametrised, registered shared-bus controller for the single-core matrix multiplier datapath. It is the successor to the combinational `read_en` bus multiplexer. It accepts queued transfer requests `{source, destination}` through a valid/ready handshake and drives one source onto a registered bus each cycle. Alongside the bus data it issues a one-hot load enable to the destination register. A hold input stalls the bus during memory wait states without losing queued requests.

## Interface
Parameters:
- `W`, default 16: bus data width. Sources narrower than `W` are zero-extended by the integrator.
- `NSRC`, default 13: number of bus sources (R, DR, TR, PC, AC, DM, IM, R1, R2, RI, RJ, RK, spare).
- `NDST`, default 16: number of destination load enables.
- `DEPTH`, default 4: request queue depth, power of two, ≥2.

Ports:
- `clk`, in, 1: clock, rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `src_bus`, in, `NSRC*W`: packed sources; source *k* occupies bits `[k*W +: W]`.
- `req_valid`, in, 1: request present.
- `req_src`, in, `$clog2(NSRC)`: source select.
- `req_dst`, in, `$clog2(NDST)`: destination index.
- `req_ready`, out, 1: queue can accept.
- `bus_hold`, in, 1: stall; no transfer issued this cycle.
- `bus_out`, out, `W`: registered bus value.
- `out_valid`, out, 1: `bus_out` carries a new transfer this cycle.
- `ld_en`, out, `NDST`: one-hot destination load enable, qualified by `out_valid`.
- `err_clr`, in, 1: clear sticky error.
- `err_sel`, out, 1: sticky illegal-source flag.

## Operation
- A request is accepted when `req_valid && req_ready` at a rising edge. The pair `{req_src, req_dst}` is pushed into the FIFO.
- `req_ready = !full`. It is computed from the registered count only. A pop in the same cycle does not admit a push when full.
- Issue: on each edge where the FIFO is non-empty and `bus_hold == 0`, the head is popped.
  - `bus_out <= src_bus[head_src*W +: W]`, sampled at that edge.
  - `ld_en <= onehot(head_dst)`.
  - `out_valid <= 1`.
- No issue (empty or hold):
  - `out_valid <= 0` and `ld_en <= 0`.
  - `bus_out` holds its last value.
- `head_src >= NSRC` is an illegal source: `bus_out <= 0`, while `ld_en` and `out_valid` still assert.
- `head_dst >= NDST` gives an all-zero `ld_en`; `out_valid` still asserts.
- Simultaneous push and pop when not full: both happen and the count is unchanged.
- Pointers wrap modulo `DEPTH`. Count width is `$clog2(DEPTH+1)`.
- No arbitration is needed; ordering is strictly FIFO.

## Timing
- Reset values:
  - `bus_out = 0`, `out_valid = 0`, `ld_en = 0`, `err_sel = 0`.
  - FIFO empty, so `req_ready = 1`.
- Latency: a request accepted at edge N appears on `bus_out`/`ld_en` after edge N+1 if the FIFO was empty and no hold is applied.
- Throughput: one transfer per cycle sustained.
- `bus_hold` stalls issue for exactly the cycles it is high. The queue keeps accepting until full.
- Reset mid-operation: queued requests are discarded and all outputs return to their reset values immediately (asynchronous).

## Configuration
- `BUS_CTRL_ERR_EN` defined:
  - `err_sel` is set on the issue edge of any illegal source.
  - It is cleared by `err_clr` (clear wins over a same-cycle set) or by reset.
- Not defined: `err_sel` is tied to 0 and `err_clr` is ignored. Datapath behaviour is identical either way.

## Structure
- `bus_ctrl_pkg`:
  - default `W`/`NSRC`/`NDST`/`DEPTH` constants.
  - named source indices (`SRC_R` = 0 … `SRC_RK` = 11).
  - `onehot` function.
- Sub-module `bus_req_fifo`: generic synchronous FIFO with parameters width and depth, and ports push/pop/full/empty/head. `bus_ctrl` instantiates it with width `$clog2(NSRC) + $clog2(NDST)`.

## Test plan
- After reset, sources *k* = 10…22 are applied.
  - Push `{src = 4, dst = 3}` → one cycle after acceptance: `bus_out = 14`, `ld_en = 16'h0008`, `out_valid = 1`.
  - The next cycle returns `out_valid = 0`.
- Back-to-back push of sources 0…7 with dst = source → eight consecutive `out_valid` cycles, `bus_out = 10, 11, …, 17` in order, no bubbles.
- Hold `bus_hold = 1` and push 5 requests → `req_ready` drops after the 4th. Release hold → 4 transfers drain in order, then the 5th is accepted.
- Change `src_bus` source 2 from 12 to 99 on the issue edge of a src = 2 request → the edge-sampled value is captured on `bus_out`.
- Push `src = 14` (≥ `NSRC`) → `bus_out = 0`, `out_valid = 1`.
  - With `BUS_CTRL_ERR_EN`: `err_sel = 1` until `err_clr`.
  - Without it: `err_sel` stays 0.
- Assert `rst_n = 0` with 3 requests queued and hold active → outputs zero immediately, `req_ready = 1`. After release, nothing issues.
